// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU result channel, load issue/return
// channel, and the register-file / CPSR write port with the busy scoreboard.
// "master" is the pipeline side that offers results; "slave" is the arbiter.
interface wb_arbiter_if #(
   parameter int DW   = 8,
   parameter int NREG = 16
);
   // ALU result channel (valid/ready)
   logic            alu_valid;
   logic            alu_ready;
   logic [3:0]      alu_rd;
   logic [DW-1:0]   alu_result;
   logic            alu_set_flags;
   logic [3:0]      alu_flags;

   // Load issue (marks destination busy) and load data return (no ready)
   logic            ld_issue;
   logic [3:0]      ld_issue_rd;
   logic            mem_valid;
   logic [3:0]      mem_rd;
   logic [DW-1:0]   mem_data;

   // Register-file write port, CPSR update port and busy scoreboard
   logic            reg_write;
   logic [3:0]      rd;
   logic [DW-1:0]   WD;
   logic            cpsr_write;
   logic [3:0]      conditions_flags;
   logic [NREG-1:0] busy_mask;

   modport master (
      output alu_valid, alu_rd, alu_result, alu_set_flags, alu_flags,
      output ld_issue, ld_issue_rd,
      output mem_valid, mem_rd, mem_data,
      input  alu_ready,
      input  reg_write, rd, WD, cpsr_write, conditions_flags, busy_mask
   );

   modport slave (
      input  alu_valid, alu_rd, alu_result, alu_set_flags, alu_flags,
      input  ld_issue, ld_issue_rd,
      input  mem_valid, mem_rd, mem_data,
      output alu_ready,
      output reg_write, rd, WD, cpsr_write, conditions_flags, busy_mask
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one register-file write per cycle, chosen from returning
// load data (highest priority), the head of a small in-order ALU result FIFO,
// or a freshly accepted ALU result that bypasses an empty FIFO. Also keeps
// the per-register busy scoreboard that decode stalls on.
// The interface instance must be built with the same DW/NREG as this module.
module wb_arbiter #(
   parameter int DW    = 8,
   parameter int NREG  = 16,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   wb_arbiter_if.slave  bus
);

   // Pointer width is kept at least 1 so DEPTH=1 still has a legal index.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   typedef struct packed {
      logic [3:0]    rd;
      logic [DW-1:0] data;
      logic          set_flags;
      logic [3:0]    flags;
   } entry_t;

   // FIFO storage and control
   entry_t          fifo_mem [DEPTH];
   logic [PW-1:0]   wr_ptr_reg;
   logic [PW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [CW-1:0]   count_next;

   // Registered write-port outputs
   logic            reg_write_reg,  reg_write_next;
   logic [3:0]      rd_reg,         rd_next;
   logic [DW-1:0]   wd_reg,         wd_next;
   logic            cpsr_write_reg, cpsr_write_next;
   logic [3:0]      flags_reg,      flags_next;

   // Scoreboard
   logic [NREG-1:0] busy_reg;
   logic [NREG-1:0] busy_next;

   // Per-cycle decisions
   logic            alu_acc;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            bypass;
   entry_t          alu_entry;
   entry_t          head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Ready is held low during reset and whenever the FIFO is full; a full
   // FIFO never passes a new result straight through.
   assign bus.alu_ready = rst_n & (count_reg < DEPTH_C);

   assign alu_acc    = bus.alu_valid & bus.alu_ready;
   assign fifo_empty = (count_reg == '0);
   assign head       = fifo_mem[rd_ptr_reg];

   assign alu_entry.rd        = bus.alu_rd;
   assign alu_entry.data      = bus.alu_result;
   assign alu_entry.set_flags = bus.alu_set_flags;
   assign alu_entry.flags     = bus.alu_flags;

   // Write-slot selection: memory return, then FIFO head, then ALU bypass.
   always_comb begin
      reg_write_next  = 1'b0;
      rd_next         = rd_reg;
      wd_next         = wd_reg;
      cpsr_write_next = 1'b0;
      flags_next      = flags_reg;
      pop             = 1'b0;
      bypass          = 1'b0;
      if (bus.mem_valid) begin
         reg_write_next = 1'b1;
         rd_next        = bus.mem_rd;
         wd_next        = bus.mem_data;
      end else if (!fifo_empty) begin
         pop            = 1'b1;
         reg_write_next = 1'b1;
         rd_next        = head.rd;
         wd_next        = head.data;
         if (head.set_flags) begin
            cpsr_write_next = 1'b1;
            flags_next      = head.flags;
         end
      end else if (alu_acc) begin
         bypass         = 1'b1;
         reg_write_next = 1'b1;
         rd_next        = alu_entry.rd;
         wd_next        = alu_entry.data;
         if (alu_entry.set_flags) begin
            cpsr_write_next = 1'b1;
            flags_next      = alu_entry.flags;
         end
      end
   end

   // Anything accepted but not bypassed joins the queue behind older entries.
   assign push = alu_acc & ~bypass;

   // Occupancy update; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + CW'(1);
      end else if (pop && !push) begin
         count_next = count_reg - CW'(1);
      end
   end

   // Scoreboard next state, one bit per register. A set on the same edge as
   // a clear wins, so a freshly issued write is never lost. A bypassed ALU
   // result is written on its accept edge, so it never marks its register.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
         logic set_bit;
         logic clr_bit;
         assign set_bit = (bus.ld_issue && (bus.ld_issue_rd == 4'(gi))) ||
                          (push && (bus.alu_rd == 4'(gi)));
         assign clr_bit = reg_write_next && (rd_next == 4'(gi));
         assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
      end
   endgenerate

   // FIFO payload storage; contents are only meaningful below count_reg, so
   // it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= alu_entry;
      end
   end

   // FIFO pointers and occupancy; reset drops every queued entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         count_reg <= count_next;
      end
   end

   // Registered write port, CPSR port and busy scoreboard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_reg  <= 1'b0;
         rd_reg         <= '0;
         wd_reg         <= '0;
         cpsr_write_reg <= 1'b0;
         flags_reg      <= '0;
         busy_reg       <= '0;
      end else begin
         reg_write_reg  <= reg_write_next;
         rd_reg         <= rd_next;
         wd_reg         <= wd_next;
         cpsr_write_reg <= cpsr_write_next;
         flags_reg      <= flags_next;
         busy_reg       <= busy_next;
      end
   end

   assign bus.reg_write        = reg_write_reg;
   assign bus.rd               = rd_reg;
   assign bus.WD               = wd_reg;
   assign bus.cpsr_write       = cpsr_write_reg;
   assign bus.conditions_flags = flags_reg;
   assign bus.busy_mask        = busy_reg;

   // Load data must only return for a register that has a pending write.
   mem_rd_busy_a : assert property (
      @(posedge clk) disable iff (!rst_n)
      bus.mem_valid |-> busy_reg[bus.mem_rd]
   );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. Stimulus pushes the hand-computed expected
// writes into a queue in landing order; a negedge monitor pops and compares
// every register-file write the arbiter presents.
module tb_wb_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   wb_arbiter_if #(.DW(8), .NREG(16)) bus ();

   wb_arbiter #(.DW(8), .NREG(16), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] rd;
      logic [7:0] wd;
      logic       cpsr;
      logic [3:0] flags;
   } wr_t;

   wr_t        exp_q[$];
   logic [3:0] last_flags = 4'h0;
   int         vectors     = 0;
   int         miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Queue one expected write; conditions_flags must show the newest flags
   // carried by a set_flags write, otherwise the value held from before.
   task automatic expect_write(input logic [3:0] r, input logic [7:0] d,
                               input logic c, input logic [3:0] f);
      wr_t e;
      if (c) last_flags = f;
      e.rd    = r;
      e.wd    = d;
      e.cpsr  = c;
      e.flags = last_flags;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_valid     = 1'b0;
      bus.alu_rd        = 4'h0;
      bus.alu_result    = 8'h00;
      bus.alu_set_flags = 1'b0;
      bus.alu_flags     = 4'h0;
      bus.ld_issue      = 1'b0;
      bus.ld_issue_rd   = 4'h0;
      bus.mem_valid     = 1'b0;
      bus.mem_rd        = 4'h0;
      bus.mem_data      = 8'h00;
   endtask

   task automatic alu(input logic [3:0] r, input logic [7:0] d,
                      input logic sf, input logic [3:0] f);
      bus.alu_valid     = 1'b1;
      bus.alu_rd        = r;
      bus.alu_result    = d;
      bus.alu_set_flags = sf;
      bus.alu_flags     = f;
   endtask

   task automatic mem(input logic [3:0] r, input logic [7:0] d);
      bus.mem_valid = 1'b1;
      bus.mem_rd    = r;
      bus.mem_data  = d;
   endtask

   task automatic issue(input logic [3:0] r);
      bus.ld_issue    = 1'b1;
      bus.ld_issue_rd = r;
   endtask

   // Monitor: one line per register-file write, compared against the queue.
   always @(negedge clk) begin
      wr_t got;
      wr_t e;
      if (rst_n && bus.reg_write) begin
         got = {bus.rd, bus.WD, bus.cpsr_write, bus.conditions_flags};
         $display("write rd=%0d WD=0x%02h cpsr_write=%0b flags=%04b",
                  bus.rd, bus.WD, bus.cpsr_write, bus.conditions_flags);
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got rd=%0d WD=0x%02h, required no write",
                     got.rd, got.wd);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               miscompares++;
               $display("FAIL write: got rd=%0d WD=0x%02h cpsr=%0b flags=%04b, required rd=%0d WD=0x%02h cpsr=%0b flags=%04b",
                        got.rd, got.wd, got.cpsr, got.flags, e.rd, e.wd, e.cpsr, e.flags);
            end
         end
      end
   end

   // Stimulus tables for the back-to-back test
   logic [3:0] t3_rd  [3] = '{4'd1, 4'd2, 4'd4};
   logic [7:0] t3_res [3] = '{8'hA1, 8'hA2, 8'hA4};
   logic       t3_sf  [3] = '{1'b0, 1'b0, 1'b1};
   logic       t3_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      int ai;
      idle();
      rst_n = 1'b0;
      #12;
      check("rst_reg_write",  32'(bus.reg_write), 32'h0);
      check("rst_rd",         32'(bus.rd), 32'h0);
      check("rst_WD",         32'(bus.WD), 32'h0);
      check("rst_cpsr_write", 32'(bus.cpsr_write), 32'h0);
      check("rst_flags",      32'(bus.conditions_flags), 32'h0);
      check("rst_busy",       32'(bus.busy_mask), 32'h0);
      check("rst_alu_ready",  32'(bus.alu_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_alu_ready", 32'(bus.alu_ready), 32'h1);

      // 1: single ALU op with flags, bypass latency of one cycle
      alu(4'd3, 8'h5A, 1'b1, 4'b1000);
      expect_write(4'd3, 8'h5A, 1'b1, 4'b1000);
      tick();
      idle();
      @(negedge clk);
      check("t1_reg_write", 32'(bus.reg_write), 32'h1);
      check("t1_busy",      32'(bus.busy_mask), 32'h0);
      tick();
      @(negedge clk);
      check("t1_single_write", 32'(bus.reg_write), 32'h0);
      check("t1_busy_after",   32'(bus.busy_mask), 32'h0);

      // 2: memory return and ALU result on the same edge
      issue(4'd5);
      tick();
      idle();
      mem(4'd5, 8'h11);
      alu(4'd2, 8'h22, 1'b0, 4'hF);
      expect_write(4'd5, 8'h11, 1'b0, 4'h0);
      expect_write(4'd2, 8'h22, 1'b0, 4'h0);
      tick();
      idle();
      @(negedge clk);
      check("t2_busy_pending", 32'(bus.busy_mask), 32'h0004);
      tick();
      @(negedge clk);
      check("t2_busy_clear", 32'(bus.busy_mask), 32'h0);
      check("t2_flags_held", 32'(bus.conditions_flags), 32'h8);
      tick();

      // 3: four memory returns against three back-to-back ALU results
      for (int r = 8; r < 12; r++) begin
         issue(4'(r));
         tick();
      end
      idle();
      for (int r = 8; r < 12; r++) expect_write(4'(r), 8'h80 + 8'(r - 8), 1'b0, 4'h0);
      for (int k = 0; k < 3; k++) expect_write(t3_rd[k], t3_res[k], t3_sf[k], 4'b0110);
      ai = 0;
      for (int c = 0; c < 7; c++) begin
         logic acc;
         if (c < 4) mem(4'(8 + c), 8'h80 + 8'(c));
         else bus.mem_valid = 1'b0;
         if (ai < 3) alu(t3_rd[ai], t3_res[ai], t3_sf[ai], t3_sf[ai] ? 4'b0110 : 4'hF);
         else bus.alu_valid = 1'b0;
         if (c < 6) check($sformatf("t3_alu_ready_c%0d", c), 32'(bus.alu_ready), 32'(t3_rdy[c]));
         acc = bus.alu_valid && bus.alu_ready;
         tick();
         if (acc) ai++;
      end
      idle();
      tick();
      @(negedge clk);
      check("t3_busy_clear", 32'(bus.busy_mask), 32'h0);
      check("t3_drained",    32'(exp_q.size()), 32'h0);

      // 4: load issue, busy held for three cycles, then the return
      issue(4'd7);
      tick();
      idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("t4_busy7_k%0d", k), 32'(bus.busy_mask[7]), 32'h1);
         if (k < 2) tick();
      end
      mem(4'd7, 8'hC3);
      expect_write(4'd7, 8'hC3, 1'b0, 4'h0);
      tick();
      idle();
      @(negedge clk);
      check("t4_busy7_clear", 32'(bus.busy_mask[7]), 32'h0);
      tick();

      // 5: reset with two ALU entries queued behind memory returns
      issue(4'd12);
      tick();
      issue(4'd13);
      tick();
      idle();
      mem(4'd12, 8'h12);
      alu(4'd6, 8'h66, 1'b1, 4'h3);
      expect_write(4'd12, 8'h12, 1'b0, 4'h0);
      tick();
      idle();
      mem(4'd13, 8'h13);
      alu(4'd9, 8'h99, 1'b0, 4'hF);
      expect_write(4'd13, 8'h13, 1'b0, 4'h0);
      tick();
      idle();
      @(negedge clk);
      check("t5_full_ready", 32'(bus.alu_ready), 32'h0);
      check("t5_busy_queued", 32'(bus.busy_mask), 32'h0240);
      #1;
      rst_n = 1'b0;
      last_flags = 4'h0;
      #1;
      check("t5_rst_reg_write", 32'(bus.reg_write), 32'h0);
      check("t5_rst_rd",        32'(bus.rd), 32'h0);
      check("t5_rst_WD",        32'(bus.WD), 32'h0);
      check("t5_rst_flags",     32'(bus.conditions_flags), 32'h0);
      check("t5_rst_busy",      32'(bus.busy_mask), 32'h0);
      check("t5_rst_alu_ready", 32'(bus.alu_ready), 32'h0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      check("t5_rel_alu_ready", 32'(bus.alu_ready), 32'h1);
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge clk);
         check($sformatf("t5_no_stale_k%0d", k), 32'(bus.reg_write), 32'h0);
      end

      // 6: load issue on the same edge as the write clearing that register
      issue(4'd4);
      tick();
      idle();
      mem(4'd4, 8'h44);
      issue(4'd4);
      expect_write(4'd4, 8'h44, 1'b0, 4'h0);
      tick();
      idle();
      @(negedge clk);
      check("t6_set_wins", 32'(bus.busy_mask), 32'h0010);
      mem(4'd4, 8'h45);
      expect_write(4'd4, 8'h45, 1'b0, 4'h0);
      tick();
      idle();
      @(negedge clk);
      check("t6_busy_clear", 32'(bus.busy_mask), 32'h0);

      repeat (3) tick();
      check("final_queue_empty", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Run-time bound: the directed sequence is far shorter than this.
   initial begin
      #100000;
      vectors++;
      miscompares++;
      $display("FAIL watchdog: got no completion, required completion before 100000ns");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
